// File: rtl/cache_axi_arbiter.sv
// Shares one AXI4 master between the I-cache (reads) and the D-cache (reads, write-backs).
// Define ROUND_ROBIN_EN for alternating read grants under contention; default is data-over-inst.
module cache_axi_arbiter #(
  parameter int          ADDR_W     = 32,
  parameter int          DATA_W     = 32,
  parameter int          LINE_OFF_W = 5,
  parameter logic [3:0]  INST_ID    = 4'd0,
  parameter logic [3:0]  DATA_ID    = 4'd1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   i_araddr,
  input  logic [7:0]          i_arlen,
  input  logic                i_arvalid,
  output logic                i_arready,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_rvalid,
  output logic                i_rlast,
  input  logic                i_rready,
  input  logic [ADDR_W-1:0]   d_araddr,
  input  logic [7:0]          d_arlen,
  input  logic [2:0]          d_arsize,
  input  logic                d_arvalid,
  output logic                d_arready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_rvalid,
  output logic                d_rlast,
  input  logic                d_rready,
  input  logic [ADDR_W-1:0]   d_awaddr,
  input  logic [7:0]          d_awlen,
  input  logic                d_awvalid,
  output logic                d_awready,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic                d_wlast,
  input  logic                d_wvalid,
  output logic                d_wready,
  output logic                d_bvalid,
  input  logic                d_bready,
  output logic [3:0]          m_arid,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [3:0]          m_rid,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [3:0]          m_awid,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [3:0]          m_wid,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic [1:0]          dbg_rd_state,
  output logic [1:0]          dbg_wr_state,
  output logic                dbg_rid_mismatch
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
  // A source holds valid and payload stable until then; ready may depend combinationally on valid.

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rd_state_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} wr_state_e;

  localparam int   LINE_W   = ADDR_W - LINE_OFF_W;
  localparam logic GNT_INST = 1'b0;
  localparam logic GNT_DATA = 1'b1;

  rd_state_e         rd_state_q, rd_state_d;
  wr_state_e         wr_state_q, wr_state_d;
  logic              gnt_q, gnt_d;
  logic [LINE_W-1:0] hz_line_q, hz_line_d;

  logic d_hazard;
  logic d_elig;
  logic r_sel_ready;
  logic rd_done;

  // Only the line part of the write-back address is kept; offsets never matter for the hazard.
  always_comb begin
    d_hazard = 1'b0;
    if (wr_state_q != W_IDLE)
      d_hazard = (d_araddr[ADDR_W-1:LINE_OFF_W] == hz_line_q);
    else if (d_awvalid)
      d_hazard = (d_araddr[ADDR_W-1:LINE_OFF_W] == d_awaddr[ADDR_W-1:LINE_OFF_W]);
  end

  assign d_elig      = d_arvalid & ~d_hazard;
  assign r_sel_ready = (gnt_q == GNT_DATA) ? d_rready : i_rready;
  assign rd_done     = (rd_state_q == R_DATA) & m_rvalid & r_sel_ready & m_rlast;

`ifdef ROUND_ROBIN_EN
  logic rr_q, rr_d;

  always_comb begin
    rr_d = rr_q;
    if (rd_done) rr_d = ~gnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= GNT_INST;
    else     rr_q <= rr_d;
  end
`endif

  // Read side: one grant from AR issue through the RLAST handshake.
  always_comb begin
    rd_state_d = rd_state_q;
    gnt_d      = gnt_q;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    i_arready  = 1'b0;
    d_arready  = 1'b0;
    i_rvalid   = 1'b0;
    d_rvalid   = 1'b0;
    m_arid     = (gnt_q == GNT_DATA) ? DATA_ID  : INST_ID;
    m_araddr   = (gnt_q == GNT_DATA) ? d_araddr : i_araddr;
    m_arlen    = (gnt_q == GNT_DATA) ? d_arlen  : i_arlen;
    m_arsize   = (gnt_q == GNT_DATA) ? d_arsize : 3'd2;
    case (rd_state_q)
      R_IDLE: begin
        if (d_elig || i_arvalid) begin
          rd_state_d = R_ADDR;
`ifdef ROUND_ROBIN_EN
          if (d_elig && i_arvalid) gnt_d = rr_q;
          else                     gnt_d = d_elig ? GNT_DATA : GNT_INST;
`else
          gnt_d = d_elig ? GNT_DATA : GNT_INST;
`endif
        end
      end
      R_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) begin
          i_arready  = (gnt_q == GNT_INST);
          d_arready  = (gnt_q == GNT_DATA);
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        m_rready = r_sel_ready;
        i_rvalid = m_rvalid & (gnt_q == GNT_INST);
        d_rvalid = m_rvalid & (gnt_q == GNT_DATA);
        if (rd_done) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;
  assign i_rlast = m_rlast & i_rvalid;
  assign d_rlast = m_rlast & d_rvalid;

  // Write side: D-cache write-back passthrough, gated to the state owning each channel.
  always_comb begin
    wr_state_d = wr_state_q;
    hz_line_d  = hz_line_q;
    m_awvalid  = 1'b0;
    d_awready  = 1'b0;
    m_wvalid   = 1'b0;
    d_wready   = 1'b0;
    d_bvalid   = 1'b0;
    m_bready   = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (d_awvalid) begin
          hz_line_d  = d_awaddr[ADDR_W-1:LINE_OFF_W];
          wr_state_d = W_ADDR;
        end
      end
      W_ADDR: begin
        m_awvalid = d_awvalid;
        d_awready = m_awready;
        if (d_awvalid && m_awready) wr_state_d = W_DATA;
      end
      W_DATA: begin
        m_wvalid = d_wvalid;
        d_wready = m_wready;
        if (d_wvalid && m_wready && d_wlast) wr_state_d = W_RESP;
      end
      W_RESP: begin
        d_bvalid = m_bvalid;
        m_bready = d_bready;
        if (m_bvalid && d_bready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  assign m_awid   = DATA_ID;
  assign m_awaddr = d_awaddr;
  assign m_awlen  = d_awlen;
  assign m_awsize = 3'd2;
  assign m_wid    = DATA_ID;
  assign m_wdata  = d_wdata;
  assign m_wstrb  = d_wstrb;
  assign m_wlast  = d_wlast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      wr_state_q <= W_IDLE;
      gnt_q      <= GNT_INST;
      hz_line_q  <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      gnt_q      <= gnt_d;
      hz_line_q  <= hz_line_d;
    end
  end

  // Routing ignores m_rid; a disagreeing id is only flagged for observation.
  assign dbg_rid_mismatch = (rd_state_q == R_DATA) & m_rvalid & (m_rid != m_arid);
  assign dbg_rd_state     = rd_state_q;
  assign dbg_wr_state     = wr_state_q;

endmodule
